pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel duty-cycle variator: a single shared period counter drives CHANNELS independent PWM outputs. Each channel's duty is stepped up or down by edge-detected increase/decrease requests. Duty and mode changes are double-buffered and take effect only at a period boundary, so outputs are glitch-free. It generalises the single-channel 10-step PWM with a parametrised period and step, saturating duty arithmetic, and a selectable edge-/center-aligned mode.

## Interface
Parameters:
- CHANNELS, 4, number of independent PWM outputs (>= 1)
- PERIOD, 10, counts per edge-aligned period; duty range is 0..PERIOD (>= 2)
- STEP, 1, duty change per accepted request (1..PERIOD)
- INITIAL_DUTY, 5, duty of every channel after reset (0..PERIOD)
- Derived: W = $clog2(PERIOD+1), width of the counter and duty registers

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- increase_duty_in  input  CHANNELS  per-channel increase request (level; rising edge acts)
- decrease_duty_in  input  CHANNELS  per-channel decrease request (level; rising edge acts)
- center_aligned_in  input  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary
- pwm_out  output  CHANNELS  PWM outputs
- period_start  output  1  high for the first cycle of every period

## Operation
- Edge detect: per channel, registered copies inc_q/dec_q; inc_ev = increase_duty_in & ~inc_q (dec_ev likewise). Holding a request high produces exactly one step.
- Pending duty (per channel, W bits):
  - inc_ev alone: pending = min(pending + STEP, PERIOD).
  - dec_ev alone: pending = max(pending - STEP, 0).
  - Both in the same cycle: no change.
  - Compute in W+1 bits; no wrap-around in either direction.
- Active duty and active mode load from pending duty / center_aligned_in on the boundary edge (defined below). An event on that same edge updates pending only, so it takes effect one period later.
- Counter, edge-aligned: counts 0,1,...,PERIOD-1, then 0. The boundary edge is the edge where cnt == PERIOD-1.
- Counter, center-aligned: direction flag dir (0 = up). Counts 0..PERIOD-1 up, then PERIOD-1..0 down; each end value is held for two cycles and the period is 2*PERIOD cycles. The flip to down happens on the edge where cnt == PERIOD-1 and dir == up. The boundary edge is the edge where cnt == 0 and dir == down; it sets dir to up and cnt stays 0.
- A mode change at the boundary restarts cleanly: cnt = 0, dir = up.
- pwm_out[i] = (cnt < active_duty[i]), combinational from registers.
  - Edge-aligned high time = duty cycles.
  - Center-aligned high time = 2*duty cycles, symmetric about the period centre.
  - duty 0 gives constant low; duty PERIOD gives constant high.
- period_start = (cnt == 0) && (dir == up).

## Timing
- Reset values: cnt = 0, dir = up, active mode = edge-aligned, pending = active = INITIAL_DUTY, inc_q = dec_q = 0.
- Outputs during reset: period_start = 1; pwm_out = all ones if INITIAL_DUTY > 0, else all zeros.
- First cycle after reset release is cycle 0 of a period.
- Request latency: an input rising at edge n updates pending at edge n. pwm_out reflects it in the first period that starts after edge n (worst case PERIOD, or 2*PERIOD in center mode, plus 1 cycle).
- A request high at reset release counts as an edge, since inc_q resets to 0.
- Reset asserted mid-period: immediate return to reset values; the partial period is discarded.
- center_aligned_in is ignored except on boundary edges.

## Test plan
- Reset, defaults (PERIOD = 10, INITIAL_DUTY = 5), no requests -> every pwm_out high 5 / low 5 repeating; period_start pulses every 10 cycles, first pulse in cycle 0.
- Channel 1 increase held high for 30 cycles -> duty becomes 6 at the next boundary and stays 6; other channels remain at 5.
- Eleven separate increase pulses on channel 0 -> duty saturates at 10 (constant high). Then eleven decrease pulses -> duty 0 (constant low). No wrap at either end.
- Increase and decrease rising in the same cycle on channel 2 -> duty unchanged. Increase arriving mid-period -> current period keeps the old waveform; next period uses the new duty.
- center_aligned_in = 1 mid-period, duty 3 -> change applies at the next boundary; then period 20 cycles, pwm_out high for cycles 0-2 and 17-19 (cnt < 3 on up and down ramps), period_start every 20 cycles.
- Reset asserted while cnt = 7 with duty 8 -> cnt, duties and outputs return to reset values asynchronously; pending requests are lost.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: shared-counter multi-channel PWM with double-buffered duty
// and a selectable edge-/center-aligned mode, all applied at period boundaries.
module pwm_multi #(
  parameter int CHANNELS     = 4,
  parameter int PERIOD       = 10,
  parameter int STEP         = 1,
  parameter int INITIAL_DUTY = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] increase_duty_in,
  input  logic [CHANNELS-1:0] decrease_duty_in,
  input  logic                center_aligned_in,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam int W  = $clog2(PERIOD + 1);
  localparam int WX = W + 1;

  localparam logic [W-1:0]  CNT_LAST  = W'(PERIOD - 1);
  localparam logic [W-1:0]  DUTY_INIT = W'(INITIAL_DUTY);
  localparam logic [W-1:0]  PER_W     = W'(PERIOD);
  localparam logic [WX-1:0] PER_X     = WX'(PERIOD);
  localparam logic [WX-1:0] STEP_X    = WX'(STEP);

  logic [W-1:0] cnt_q, cnt_d;
  logic         dir_q, dir_d;
  logic         mode_q, mode_d;
  logic         boundary;

  logic [CHANNELS-1:0] inc_q, dec_q;
  logic [CHANNELS-1:0] inc_ev, dec_ev;

  logic [CHANNELS-1:0][W-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0][W-1:0] act_q, act_d;

  assign inc_ev = increase_duty_in & ~inc_q;
  assign dec_ev = decrease_duty_in & ~dec_q;

  // Period boundary: last edge-aligned count, or the down-ramp low end.
  always_comb begin
    if (mode_q) begin
      boundary = (cnt_q == '0) && dir_q;
    end else begin
      boundary = (cnt_q == CNT_LAST);
    end
  end

  // Counter/direction/mode next state; boundary restarts cleanly at 0, up.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (boundary) begin
      cnt_d  = '0;
      dir_d  = 1'b0;
      mode_d = center_aligned_in;
    end else if (!mode_q) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!dir_q) begin
      if (cnt_q == CNT_LAST) begin
        dir_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pending duty: saturating step per edge event; simultaneous events cancel.
  always_comb begin
    logic [WX-1:0] cur;
    logic [WX-1:0] up;
    pend_d = pend_q;
    cur    = '0;
    up     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cur = {1'b0, pend_q[i]};
      up  = cur + STEP_X;
      if (inc_ev[i] && !dec_ev[i]) begin
        pend_d[i] = (up > PER_X) ? PER_W : up[W-1:0];
      end else if (dec_ev[i] && !inc_ev[i]) begin
        pend_d[i] = (cur < STEP_X) ? '0 : W'(cur - STEP_X);
      end
    end
  end

  // Active duty only reloads at the boundary so waveforms never glitch.
  always_comb begin
    act_d = boundary ? pend_q : act_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= 1'b0;
      inc_q  <= '0;
      dec_q  <= '0;
      pend_q <= {CHANNELS{DUTY_INIT}};
      act_q  <= {CHANNELS{DUTY_INIT}};
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      inc_q  <= increase_duty_in;
      dec_q  <= decrease_duty_in;
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    pwm_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_out[i] = (cnt_q < act_q[i]);
    end
    period_start = (cnt_q == '0) && !dir_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: scoreboard bench for pwm_multi; a phase-based reference
// model queues the expected {pwm_out, period_start} for every clock.
module tb_pwm_multi;

  localparam int CH    = 4;
  localparam int P     = 10;
  localparam int IDUTY = 5;
  localparam int VW    = CH + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] inc_r = '0;
  logic [CH-1:0] dec_r = '0;
  logic          ca_r = 1'b0;
  logic [CH-1:0] pwm;
  logic          ps;

  pwm_multi #(
    .CHANNELS    (CH),
    .PERIOD      (P),
    .STEP        (1),
    .INITIAL_DUTY(IDUTY)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .increase_duty_in (inc_r),
    .decrease_duty_in (dec_r),
    .center_aligned_in(ca_r),
    .pwm_out          (pwm),
    .period_start     (ps)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  logic [VW-1:0] sb[$];

  int            m_t;
  int            m_mode;
  int            m_pend[CH];
  int            m_act[CH];
  logic [CH-1:0] m_incq;
  logic [CH-1:0] m_decq;

  task automatic chk(string tag, logic [VW-1:0] got, logic [VW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] m_out();
    logic [VW-1:0] r;
    int len;
    len = P * (m_mode + 1);
    r = '0;
    for (int i = 0; i < CH; i++) begin
      if (m_mode != 0)
        r[i+1] = (m_t < m_act[i]) || (m_t >= len - m_act[i]);
      else
        r[i+1] = (m_t < m_act[i]);
    end
    r[0] = (m_t == 0);
    return r;
  endfunction

  task automatic m_reset();
    m_t    = 0;
    m_mode = 0;
    m_incq = '0;
    m_decq = '0;
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = IDUTY;
      m_act[i]  = IDUTY;
    end
  endtask

  task automatic m_step(logic [CH-1:0] inc, logic [CH-1:0] dec, logic ca);
    logic [CH-1:0] ie;
    logic [CH-1:0] de;
    ie = inc & ~m_incq;
    de = dec & ~m_decq;
    if (m_t == P * (m_mode + 1) - 1) begin
      for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
      m_mode = ca ? 1 : 0;
      m_t = 0;
    end else begin
      m_t++;
    end
    for (int i = 0; i < CH; i++) begin
      if (ie[i] && !de[i])
        m_pend[i] = (m_pend[i] + 1 > P) ? P : m_pend[i] + 1;
      else if (de[i] && !ie[i])
        m_pend[i] = (m_pend[i] - 1 < 0) ? 0 : m_pend[i] - 1;
    end
    m_incq = inc;
    m_decq = dec;
  endtask

  task automatic tick(logic [CH-1:0] inc, logic [CH-1:0] dec,
                      logic ca, string tag);
    logic [VW-1:0] e;
    inc_r = inc;
    dec_r = dec;
    ca_r  = ca;
    m_step(inc, dec, ca);
    sb.push_back(m_out());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(tag, {pwm, ps}, e);
  endtask

  task automatic idle(int n, string tag);
    repeat (n) tick(inc_r, dec_r, ca_r, tag);
  endtask

  task automatic pulse(int ch, bit up);
    logic [CH-1:0] m;
    m = '0;
    m[ch] = 1'b1;
    if (up) begin
      tick(inc_r | m, dec_r, ca_r, "inc_pulse");
      tick(inc_r & ~m, dec_r, ca_r, "inc_pulse");
    end else begin
      tick(inc_r, dec_r | m, ca_r, "dec_pulse");
      tick(inc_r, dec_r & ~m, ca_r, "dec_pulse");
    end
  endtask

  task automatic count_hi(int ch, int n, output int c);
    c = 0;
    repeat (n) begin
      tick(inc_r, dec_r, ca_r, "count");
      c += int'(pwm[ch]);
    end
  endtask

  task automatic advance_to(int t, string tag);
    for (int k = 0; k < 25 && m_t != t; k++) tick(inc_r, dec_r, ca_r, tag);
    chk({tag, "_reach"}, VW'(m_t), VW'(t));
  endtask

  initial begin
    int c;
    m_reset();
    #12;
    chk("reset_state", {pwm, ps}, {VW{1'b1}});
    reset = 1'b0;

    idle(30, "default");

    repeat (30) tick(4'b0010, '0, 1'b0, "inc_hold");
    idle(20, "after_hold");
    count_hi(1, P, c);
    chk("ch1_duty6", VW'(c), VW'(6));

    repeat (11) pulse(0, 1'b1);
    idle(20, "sat_wait");
    for (int k = 0; k < P; k++) begin
      tick('0, '0, 1'b0, "sat_hi");
      chk("ch0_const_hi", VW'(pwm[0]), VW'(1));
    end

    repeat (11) pulse(0, 1'b0);
    idle(20, "zero_wait");
    for (int k = 0; k < P; k++) begin
      tick('0, '0, 1'b0, "sat_lo");
      chk("ch0_const_lo", VW'(pwm[0]), VW'(0));
    end

    tick(4'b0100, 4'b0100, 1'b0, "both");
    tick('0, '0, 1'b0, "both");
    idle(20, "both_wait");
    count_hi(2, P, c);
    chk("ch2_unchanged", VW'(c), VW'(5));

    advance_to(4, "mid");
    pulse(3, 1'b1);
    idle(30, "mid_inc");

    repeat (3) pulse(3, 1'b0);
    idle(20, "duty3_wait");
    advance_to(5, "ca_mid");
    idle(1, "ca_mid");
    repeat (60) tick('0, '0, 1'b1, "center");
    count_hi(3, 2 * P, c);
    chk("ch3_center_hi", VW'(c), VW'(6));
    count_hi(1, 2 * P, c);
    chk("ch1_center_hi", VW'(c), VW'(12));

    repeat (30) tick('0, '0, 1'b0, "to_edge");

    repeat (8) pulse(0, 1'b1);
    idle(20, "duty8_wait");
    pulse(2, 1'b1);
    advance_to(7, "pre_rst");
    chk("pre_rst_ch0", VW'(pwm[0]), VW'(1));

    #2;
    reset = 1'b1;
    m_reset();
    #1;
    sb.push_back(m_out());
    chk("async_rst", {pwm, ps}, sb.pop_front());
    @(posedge clk);
    #1;
    chk("rst_hold", {pwm, ps}, {VW{1'b1}});
    #2;
    reset = 1'b0;
    idle(30, "post_rst");
    count_hi(2, P, c);
    chk("ch2_lost", VW'(c), VW'(5));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
